// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the fetch-PC hazard controller: FSM encoding, event
// classes, pipeline-control bundle and well-known instruction/register constants.
package pipe_ctrl_pkg;

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    RUN   = 3'd1,
    STALL = 3'd2,
    FLUSH = 3'd3,
    EXC   = 3'd4
  } pc_state_e;

  // Winning event of the current cycle after priority resolution.
  typedef enum logic [2:0] {
    EV_NONE,
    EV_EXC,
    EV_BRANCH,
    EV_JUMP,
    EV_LOAD_USE
  } pc_event_e;

  typedef struct packed {
    logic d_h;
    logic c_h;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
  } pipe_ctrl_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [4:0]  REG_ZERO  = 5'd0;

  // Normal streaming: PC advances, IF/ID loads, no bubbles.
  function automatic pipe_ctrl_t ctrl_sequential();
    pipe_ctrl_t c;
    c.d_h          = 1'b0;
    c.c_h          = 1'b0;
    c.if_id_write  = 1'b1;
    c.if_id_flush  = 1'b0;
    c.id_ex_bubble = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/pc_hazard_controller_load_use_detect.sv
// Load-use hazard compare: a load in EX whose destination feeds an ID-stage source.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       mem_read_i,
  input  logic [4:0] ex_rt_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  output logic       load_use_o
);

  always_comb begin
    load_use_o = mem_read_i
               && (ex_rt_i != REG_ZERO)
               && ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));
  end

endmodule

// File: rtl/pc_hazard_controller.sv
// Fetch PC sequencer: selects next PC, drives PC hold/clear and IF/ID, ID/EX
// stall/flush strobes, and keeps saturating debug event counters.
module pc_hazard_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned       N         = 32,
  parameter logic [N-1:0]      RESET_PC  = N'(32'h003F_FFFC),
  parameter int unsigned       FLUSH_LEN = 1,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N-1:0]     pc_cur,
  input  logic             id_jump,
  input  logic [N-1:0]     id_jump_target,
  input  logic             ex_branch_tkn,
  input  logic [N-1:0]     ex_branch_tgt,
  input  logic             id_ex_mem_read,
  input  logic [4:0]       id_ex_rt,
  input  logic [4:0]       if_id_rs,
  input  logic [4:0]       if_id_rt,
  input  logic             exc_req,
  output logic [N-1:0]     pc_in,
  output logic             d_h,
  output logic             c_h,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam bit         USE_FLUSH    = (FLUSH_LEN > 1);
  // Down-counter holds the number of FLUSH cycles still to follow the current one.
  localparam logic [1:0] FLUSH_RELOAD = (FLUSH_LEN > 1) ? 2'(FLUSH_LEN - 2) : 2'd0;

  pc_state_e        state_q, state_d;
  logic [1:0]       fcnt_q, fcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             load_use;
  logic [N-1:0]     pc_seq;
  pc_event_e        ev;
  pipe_ctrl_t       ctrl;

  load_use_detect u_load_use (
    .mem_read_i (id_ex_mem_read),
    .ex_rt_i    (id_ex_rt),
    .id_rs_i    (if_id_rs),
    .id_rt_i    (if_id_rt),
    .load_use_o (load_use)
  );

  assign pc_seq = pc_cur + N'(4);

  // STALL and FLUSH only honour exceptions and branches; the ID slot they
  // would otherwise examine is either already stalled or being flushed.
  always_comb begin
    ev = EV_NONE;
    unique case (state_q)
      RUN: begin
        if (exc_req)            ev = EV_EXC;
        else if (ex_branch_tkn) ev = EV_BRANCH;
        else if (id_jump)       ev = EV_JUMP;
        else if (load_use)      ev = EV_LOAD_USE;
      end
      STALL, FLUSH: begin
        if (exc_req)            ev = EV_EXC;
        else if (ex_branch_tkn) ev = EV_BRANCH;
      end
      default: ev = EV_NONE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= BOOT;
      fcnt_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    unique case (ev)
      EV_EXC: state_d = EXC;
      EV_BRANCH, EV_JUMP: begin
        if (USE_FLUSH) begin
          state_d = FLUSH;
          fcnt_d  = FLUSH_RELOAD;
        end else begin
          state_d = RUN;
        end
      end
      EV_LOAD_USE: state_d = STALL;
      default: begin
        unique case (state_q)
          FLUSH: begin
            if (fcnt_q == 2'd0) state_d = RUN;
            else                fcnt_d  = fcnt_q - 2'd1;
          end
          default: state_d = RUN;
        endcase
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((ev == EV_LOAD_USE) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (((ev == EV_EXC) || (ev == EV_BRANCH) || (ev == EV_JUMP)) && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // Outputs follow reset combinationally so a mid-cycle reset takes effect at once.
  always_comb begin
    pc_in = pc_seq;
    ctrl  = ctrl_sequential();
    if (!reset) begin
      pc_in             = RESET_PC;
      ctrl.if_id_write  = 1'b0;
      ctrl.if_id_flush  = 1'b1;
      ctrl.id_ex_bubble = 1'b1;
    end else begin
      unique case (ev)
        EV_EXC: begin
          pc_in             = '0;
          ctrl.c_h          = 1'b1;
          ctrl.if_id_flush  = 1'b1;
          ctrl.id_ex_bubble = 1'b1;
        end
        EV_BRANCH: begin
          pc_in             = ex_branch_tgt;
          ctrl.if_id_flush  = 1'b1;
          ctrl.id_ex_bubble = 1'b1;
        end
        EV_JUMP: begin
          pc_in            = id_jump_target;
          ctrl.if_id_flush = 1'b1;
        end
        EV_LOAD_USE: begin
          ctrl.d_h          = 1'b1;
          ctrl.if_id_write  = 1'b0;
          ctrl.id_ex_bubble = 1'b1;
        end
        default: begin
          unique case (state_q)
            BOOT: begin
              ctrl.if_id_write  = 1'b0;
              ctrl.if_id_flush  = 1'b1;
              ctrl.id_ex_bubble = 1'b1;
            end
            EXC: ctrl.if_id_flush = 1'b1;
            FLUSH: begin
              ctrl.if_id_flush  = 1'b1;
              ctrl.id_ex_bubble = 1'b1;
            end
            default: ctrl = ctrl_sequential();
          endcase
        end
      endcase
    end
  end

  assign d_h          = ctrl.d_h;
  assign c_h          = ctrl.c_h;
  assign if_id_write  = ctrl.if_id_write;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_bubble = ctrl.id_ex_bubble;
  assign state_o      = state_q;
  assign stall_cnt    = stall_cnt_q;
  assign flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_pc_hazard_controller.sv
// Bench for pc_hazard_controller: directed scenarios plus randomized traffic
// against an event-level reference model, on FLUSH_LEN=3/CNT_W=4 and default instances.
`timescale 1ns/1ps
module tb_pc_hazard_controller;

  localparam logic [31:0] RST_PC = 32'h003F_FFFC;
  localparam int FLEN [2] = '{3, 1};
  localparam int CMAX [2] = '{15, 65535};

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc_cur = RST_PC;
  logic        id_jump = 1'b0, ex_branch_tkn = 1'b0, id_ex_mem_read = 1'b0, exc_req = 1'b0;
  logic [31:0] id_jump_target = '0, ex_branch_tgt = '0;
  logic [4:0]  id_ex_rt = '0, if_id_rs = '0, if_id_rt = '0;

  logic [31:0] pc_in_w [2];
  logic        dh_w [2], ch_w [2], wr_w [2], fl_w [2], bub_w [2];
  logic [2:0]  st_w [2];
  logic [3:0]  scnt0, fcnt0;
  logic [15:0] scnt1, fcnt1;
  logic [15:0] scnt_w [2], fcnt_w [2];

  assign scnt_w[0] = {12'd0, scnt0};
  assign fcnt_w[0] = {12'd0, fcnt0};
  assign scnt_w[1] = scnt1;
  assign fcnt_w[1] = fcnt1;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  pc_hazard_controller #(.N(32), .RESET_PC(RST_PC), .FLUSH_LEN(3), .CNT_W(4)) dut (
    .clock(clock), .reset(reset), .pc_cur(pc_cur),
    .id_jump(id_jump), .id_jump_target(id_jump_target),
    .ex_branch_tkn(ex_branch_tkn), .ex_branch_tgt(ex_branch_tgt),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .exc_req(exc_req),
    .pc_in(pc_in_w[0]), .d_h(dh_w[0]), .c_h(ch_w[0]), .if_id_write(wr_w[0]),
    .if_id_flush(fl_w[0]), .id_ex_bubble(bub_w[0]), .state_o(st_w[0]),
    .stall_cnt(scnt0), .flush_cnt(fcnt0)
  );

  pc_hazard_controller #(.FLUSH_LEN(1)) dut1 (
    .clock(clock), .reset(reset), .pc_cur(pc_cur),
    .id_jump(id_jump), .id_jump_target(id_jump_target),
    .ex_branch_tkn(ex_branch_tkn), .ex_branch_tgt(ex_branch_tgt),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .exc_req(exc_req),
    .pc_in(pc_in_w[1]), .d_h(dh_w[1]), .c_h(ch_w[1]), .if_id_write(wr_w[1]),
    .if_id_flush(fl_w[1]), .id_ex_bubble(bub_w[1]), .state_o(st_w[1]),
    .stall_cnt(scnt1), .flush_cnt(fcnt1)
  );

  // Reference model: which kind of cycle each instance is in, how many flush
  // cycles remain, and plain integer event counts.
  bit m_boot [2]  = '{1'b1, 1'b1};
  bit m_exc [2]   = '{1'b0, 1'b0};
  bit m_stall [2] = '{1'b0, 1'b0};
  int m_left [2]  = '{0, 0};
  int m_scnt [2]  = '{0, 0};
  int m_fcnt [2]  = '{0, 0};

  typedef struct packed {
    logic [31:0] pc;
    logic d, c, w, f, b;
    logic chk_pc;
  } exp_t;

  function automatic bit lu_now();
    return id_ex_mem_read && (id_ex_rt != 5'd0) && (id_ex_rt == if_id_rs || id_ex_rt == if_id_rt);
  endfunction

  // 0 none, 1 exception, 2 branch, 3 jump, 4 load-use
  function automatic int ev_of(int k);
    if (m_boot[k] || m_exc[k]) return 0;
    if (exc_req)               return 1;
    if (ex_branch_tkn)         return 2;
    if (m_stall[k] || m_left[k] > 0) return 0;
    if (id_jump)               return 3;
    if (lu_now())              return 4;
    return 0;
  endfunction

  function automatic logic [2:0] exp_state(int k);
    if (m_boot[k])       return 3'd0;
    if (m_exc[k])        return 3'd4;
    if (m_stall[k])      return 3'd2;
    if (m_left[k] > 0)   return 3'd3;
    return 3'd1;
  endfunction

  function automatic exp_t exp_of(int k);
    exp_t x;
    x.pc = pc_cur + 32'd4;
    x.d = 1'b0; x.c = 1'b0; x.w = 1'b1; x.f = 1'b0; x.b = 1'b0; x.chk_pc = 1'b1;
    if (!reset) begin
      x.pc = RST_PC; x.w = 1'b0; x.f = 1'b1; x.b = 1'b1;
      return x;
    end
    if (m_boot[k]) begin
      x.w = 1'b0; x.f = 1'b1; x.b = 1'b1;
      return x;
    end
    if (m_exc[k]) begin
      x.f = 1'b1;
      return x;
    end
    case (ev_of(k))
      1: begin x.c = 1'b1; x.f = 1'b1; x.b = 1'b1; x.chk_pc = 1'b0; end
      2: begin x.pc = ex_branch_tgt; x.f = 1'b1; x.b = 1'b1; end
      3: begin x.pc = id_jump_target; x.f = 1'b1; end
      4: begin x.d = 1'b1; x.w = 1'b0; x.b = 1'b1; end
      default: if (m_left[k] > 0) begin x.f = 1'b1; x.b = 1'b1; end
    endcase
    return x;
  endfunction

  int  mdl_e;
  bit  mdl_wf;
  always @(posedge clock or negedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        m_boot[k] = 1'b1; m_exc[k] = 1'b0; m_stall[k] = 1'b0;
        m_left[k] = 0; m_scnt[k] = 0; m_fcnt[k] = 0;
      end else begin
        mdl_e  = ev_of(k);
        mdl_wf = (m_left[k] > 0);
        m_boot[k] = 1'b0; m_exc[k] = 1'b0; m_stall[k] = 1'b0;
        case (mdl_e)
          1: begin
            m_exc[k] = 1'b1; m_left[k] = 0;
            if (m_fcnt[k] < CMAX[k]) m_fcnt[k]++;
          end
          2, 3: begin
            m_left[k] = FLEN[k] - 1;
            if (m_fcnt[k] < CMAX[k]) m_fcnt[k]++;
          end
          4: begin
            m_stall[k] = 1'b1;
            if (m_scnt[k] < CMAX[k]) m_scnt[k]++;
          end
          default: if (mdl_wf) m_left[k]--;
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    id_jump = 1'b0; ex_branch_tkn = 1'b0; id_ex_mem_read = 1'b0; exc_req = 1'b0;
    id_ex_rt = 5'd0; if_id_rs = 5'd1; if_id_rt = 5'd2;
  endtask

  task automatic test_reset();
    reset = 1'b0; idle(); pc_cur = RST_PC;
    repeat (3) @(negedge clock);
    total++; if ({pc_in_w[0], dh_w[0], ch_w[0], wr_w[0], fl_w[0], bub_w[0]} !== {RST_PC, 5'b00011}) begin
      bad++; $display("FAIL reset_outputs got=%h/%b%b%b%b%b exp=%h/00011", pc_in_w[0], dh_w[0], ch_w[0], wr_w[0], fl_w[0], bub_w[0], RST_PC);
    end
    total++; if ({st_w[0], scnt0, fcnt0} !== 11'd0) begin
      bad++; $display("FAIL reset_state got st=%0d s=%0d f=%0d exp 0/0/0", st_w[0], scnt0, fcnt0);
    end
    tick(); reset = 1'b1;
    @(negedge clock);
    total++; if (st_w[0] !== 3'd0 || pc_in_w[0] !== 32'h0040_0000 || fl_w[0] !== 1'b1) begin
      bad++; $display("FAIL boot_cycle got st=%0d pc=%h fl=%b exp st=0 pc=00400000 fl=1", st_w[0], pc_in_w[0], fl_w[0]);
    end
    tick(); pc_cur = 32'h0040_0000;
    @(negedge clock);
    total++; if (st_w[0] !== 3'd1 || pc_in_w[0] !== 32'h0040_0004 || wr_w[0] !== 1'b1 || fl_w[0] !== 1'b0) begin
      bad++; $display("FAIL first_run got st=%0d pc=%h wr=%b fl=%b exp st=1 pc=00400004 wr=1 fl=0", st_w[0], pc_in_w[0], wr_w[0], fl_w[0]);
    end
    tick();
  endtask

  task automatic test_load_use();
    pc_cur = 32'h0040_0010; id_ex_mem_read = 1'b1; id_ex_rt = 5'd8; if_id_rs = 5'd8; if_id_rt = 5'd9;
    @(negedge clock);
    total++; if ({dh_w[0], ch_w[0], wr_w[0], bub_w[0]} !== 4'b1001 || pc_in_w[0] !== 32'h0040_0014) begin
      bad++; $display("FAIL lu_detect got d/c/w/b=%b%b%b%b pc=%h exp 1001 pc=00400014", dh_w[0], ch_w[0], wr_w[0], bub_w[0], pc_in_w[0]);
    end
    tick();
    @(negedge clock);
    total++; if (st_w[0] !== 3'd2 || scnt0 !== 4'd1 || dh_w[0] !== 1'b0 || wr_w[0] !== 1'b1) begin
      bad++; $display("FAIL lu_stall got st=%0d s=%0d d=%b w=%b exp st=2 s=1 d=0 w=1", st_w[0], scnt0, dh_w[0], wr_w[0]);
    end
    tick(); idle();
    @(negedge clock);
    total++; if (st_w[0] !== 3'd1 || scnt0 !== 4'd1) begin
      bad++; $display("FAIL lu_back_run got st=%0d s=%0d exp st=1 s=1", st_w[0], scnt0);
    end
    id_ex_mem_read = 1'b1; id_ex_rt = 5'd0; if_id_rs = 5'd0;
    #1;
    total++; if (dh_w[0] !== 1'b0 || wr_w[0] !== 1'b1 || bub_w[0] !== 1'b0) begin
      bad++; $display("FAIL lu_reg_zero got d=%b w=%b b=%b exp 0 1 0", dh_w[0], wr_w[0], bub_w[0]);
    end
    tick(); idle();
  endtask

  task automatic test_branch_over_load_use();
    id_ex_mem_read = 1'b1; id_ex_rt = 5'd8; if_id_rs = 5'd8;
    ex_branch_tkn = 1'b1; ex_branch_tgt = 32'h0040_0040;
    @(negedge clock);
    total++; if (pc_in_w[0] !== 32'h0040_0040 || {dh_w[0], fl_w[0], bub_w[0]} !== 3'b011) begin
      bad++; $display("FAIL br_pri got pc=%h d/f/b=%b%b%b exp pc=00400040 011", pc_in_w[0], dh_w[0], fl_w[0], bub_w[0]);
    end
    tick(); idle();
    @(negedge clock);
    total++; if (fcnt0 !== 4'd1 || scnt0 !== 4'd1 || st_w[0] !== 3'd3) begin
      bad++; $display("FAIL br_counts got f=%0d s=%0d st=%0d exp f=1 s=1 st=3", fcnt0, scnt0, st_w[0]);
    end
    total++; if (st_w[1] !== 3'd1 || fcnt1 !== 16'd1) begin
      bad++; $display("FAIL br_len1 got st=%0d f=%0d exp st=1 f=1", st_w[1], fcnt1);
    end
    tick(); tick();
  endtask

  task automatic test_jump_flush();
    pc_cur = 32'h0040_0050; id_jump = 1'b1; id_jump_target = 32'h0040_0100;
    @(negedge clock);
    total++; if (pc_in_w[0] !== 32'h0040_0100 || fl_w[0] !== 1'b1 || bub_w[0] !== 1'b0) begin
      bad++; $display("FAIL jump_redirect got pc=%h f=%b b=%b exp pc=00400100 f=1 b=0", pc_in_w[0], fl_w[0], bub_w[0]);
    end
    tick(); idle(); pc_cur = 32'h0040_0100;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      total++; if (st_w[0] !== 3'd3 || fl_w[0] !== 1'b1 || bub_w[0] !== 1'b1 || pc_in_w[0] !== 32'h0040_0104) begin
        bad++; $display("FAIL jump_flush%0d got st=%0d f=%b b=%b pc=%h exp st=3 f=1 b=1 pc=00400104", i, st_w[0], fl_w[0], bub_w[0], pc_in_w[0]);
      end
      tick();
    end
    @(negedge clock);
    total++; if (st_w[0] !== 3'd1 || fl_w[0] !== 1'b0 || wr_w[0] !== 1'b1 || fcnt0 !== 4'd2) begin
      bad++; $display("FAIL jump_done got st=%0d f=%b w=%b fc=%0d exp st=1 f=0 w=1 fc=2", st_w[0], fl_w[0], wr_w[0], fcnt0);
    end
    tick();
  endtask

  task automatic test_exc_and_reset();
    id_ex_mem_read = 1'b1; id_ex_rt = 5'd4; if_id_rt = 5'd4;
    tick(); idle(); exc_req = 1'b1;
    @(negedge clock);
    total++; if (st_w[0] !== 3'd2 || ch_w[0] !== 1'b1 || dh_w[0] !== 1'b0 || fl_w[0] !== 1'b1) begin
      bad++; $display("FAIL exc_in_stall got st=%0d c=%b d=%b f=%b exp st=2 c=1 d=0 f=1", st_w[0], ch_w[0], dh_w[0], fl_w[0]);
    end
    tick(); exc_req = 1'b0;
    @(negedge clock);
    total++; if (st_w[0] !== 3'd4 || fl_w[0] !== 1'b1 || ch_w[0] !== 1'b0) begin
      bad++; $display("FAIL exc_state got st=%0d f=%b c=%b exp st=4 f=1 c=0", st_w[0], fl_w[0], ch_w[0]);
    end
    tick();
    @(negedge clock);
    total++; if (st_w[0] !== 3'd1 || fcnt0 !== 4'd3) begin
      bad++; $display("FAIL exc_return got st=%0d fc=%0d exp st=1 fc=3", st_w[0], fcnt0);
    end
    ex_branch_tkn = 1'b1;
    tick(); idle();
    @(negedge clock);
    reset = 1'b0;
    #1;
    total++; if (st_w[0] !== 3'd0 || {pc_in_w[0], dh_w[0], ch_w[0], wr_w[0], fl_w[0], bub_w[0]} !== {RST_PC, 5'b00011}
                 || scnt0 !== 4'd0 || fcnt0 !== 4'd0) begin
      bad++; $display("FAIL reset_mid_flush got st=%0d pc=%h ctl=%b%b%b%b%b s=%0d f=%0d exp st=0 pc=%h 00011 0 0",
                      st_w[0], pc_in_w[0], dh_w[0], ch_w[0], wr_w[0], fl_w[0], bub_w[0], scnt0, fcnt0, RST_PC);
    end
    tick(); reset = 1'b1;
    tick();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      id_ex_mem_read = 1'b1; id_ex_rt = 5'd3; if_id_rs = 5'd3;
      tick(); idle();
      tick();
    end
    @(negedge clock);
    total++; if (scnt0 !== 4'hF || scnt1 !== 16'd20) begin
      bad++; $display("FAIL stall_saturate got s0=%0d s1=%0d exp 15 20", scnt0, scnt1);
    end
    pc_cur = 32'hFFFF_FFFC;
    #1;
    total++; if (pc_in_w[0] !== 32'h0 || pc_in_w[1] !== 32'h0) begin
      bad++; $display("FAIL pc_wrap got %h %h exp 00000000", pc_in_w[0], pc_in_w[1]);
    end
    tick();
  endtask

  task automatic test_random();
    exp_t x;
    logic [31:0] m_pc;
    for (int n = 0; n < 800; n++) begin
      reset          = ($urandom_range(0, 79) != 0);
      pc_cur         = $urandom;
      id_jump        = ($urandom_range(0, 7) == 0);
      id_jump_target = $urandom;
      ex_branch_tkn  = ($urandom_range(0, 7) == 0);
      ex_branch_tgt  = $urandom;
      exc_req        = ($urandom_range(0, 19) == 0);
      id_ex_mem_read = ($urandom_range(0, 2) == 0);
      id_ex_rt       = 5'($urandom_range(0, 3));
      if_id_rs       = 5'($urandom_range(0, 3));
      if_id_rt       = 5'($urandom_range(0, 3));
      @(negedge clock);
      for (int k = 0; k < 2; k++) begin
        x = exp_of(k);
        m_pc = x.chk_pc ? x.pc : pc_in_w[k];
        total++;
        if ({m_pc, x.d, x.c, x.w, x.f, x.b, exp_state(k), 16'(m_scnt[k]), 16'(m_fcnt[k])}
            !== {pc_in_w[k], dh_w[k], ch_w[k], wr_w[k], fl_w[k], bub_w[k], st_w[k], scnt_w[k], fcnt_w[k]}) begin
          bad++;
          $display("FAIL rand[%0d] inst%0d got pc=%h ctl=%b%b%b%b%b st=%0d s=%0d f=%0d exp pc=%h ctl=%b%b%b%b%b st=%0d s=%0d f=%0d",
                   n, k, pc_in_w[k], dh_w[k], ch_w[k], wr_w[k], fl_w[k], bub_w[k], st_w[k], scnt_w[k], fcnt_w[k],
                   m_pc, x.d, x.c, x.w, x.f, x.b, exp_state(k), m_scnt[k], m_fcnt[k]);
        end
      end
      tick();
    end
    reset = 1'b1;
    idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_over_load_use();
    test_jump_flush();
    test_exc_and_reset();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
